// File: rtl/cpu_pkg.sv
// Shared constants and sequencer state encoding for the GPR port sequencer and its bench.
package cpu_pkg;

    localparam int CPU_DATA_W    = 8;
    localparam int CPU_REG_IDX_W = 3;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_READ   = 3'd1,
        SEQ_LATCH  = 3'd2,
        SEQ_OPER   = 3'd3,
        SEQ_RESULT = 3'd4,
        SEQ_WRITE  = 3'd5
    } seq_state_e;

    // A multiply always writes back, since its high half must reach the file.
    function automatic logic wb_effective(input logic wb, input logic mul);
        return wb | mul;
    endfunction

endpackage

// File: rtl/gpr_port_sequencer.sv
// Purpose: drives the register file port for one read-ALU-writeback operation at a time.
// Latency: accept at edge N -> op_valid in cycle N+3; result handshake at edge M -> write in cycle M+1.
// Backpressure: req_ready only in IDLE; stalls indefinitely in OPER/RESULT on op_ready/res_valid.
module gpr_port_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W    = CPU_DATA_W,
    parameter int REG_IDX_W = CPU_REG_IDX_W
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic [REG_IDX_W-1:0] i_req_src_a,
    input  logic [REG_IDX_W-1:0] i_req_src_b,
    input  logic [REG_IDX_W-1:0] i_req_dst,
    input  logic                 i_req_wb,
    input  logic                 i_req_mul,
    output logic                 o_op_valid,
    input  logic                 i_op_ready,
    output logic [DATA_W-1:0]    o_op_a,
    output logic [DATA_W-1:0]    o_op_b,
    input  logic                 i_res_valid,
    output logic                 o_res_ready,
    input  logic [DATA_W-1:0]    i_res_lo,
    input  logic [DATA_W-1:0]    i_res_hi,
    output logic                 o_rf_read_en,
    output logic                 o_rf_write_en,
    output logic [REG_IDX_W-1:0] o_rf_a_num,
    output logic [REG_IDX_W-1:0] o_rf_b_num,
    output logic [REG_IDX_W-1:0] o_rf_c_num,
    output logic [DATA_W-1:0]    o_rf_c_data,
    output logic [DATA_W-1:0]    o_rf_mul_high,
    input  logic [DATA_W-1:0]    i_rf_a_data,
    input  logic [DATA_W-1:0]    i_rf_b_data,
    output logic                 o_busy
);

    localparam logic [2:0] S_IDLE   = SEQ_IDLE;
    localparam logic [2:0] S_READ   = SEQ_READ;
    localparam logic [2:0] S_LATCH  = SEQ_LATCH;
    localparam logic [2:0] S_OPER   = SEQ_OPER;
    localparam logic [2:0] S_RESULT = SEQ_RESULT;
    localparam logic [2:0] S_WRITE  = SEQ_WRITE;

    typedef struct packed {
        logic [REG_IDX_W-1:0] src_a;
        logic [REG_IDX_W-1:0] src_b;
        logic [REG_IDX_W-1:0] dst;
        logic                 mul;
        logic                 wb_eff;
    } req_t;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    req_t              r_req;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [DATA_W-1:0] r_res_lo;
    logic [DATA_W-1:0] r_mul_high;

    logic w_req_fire;
    logic w_op_fire;
    logic w_res_fire;

    assign w_req_fire = (r_state == S_IDLE)   && i_req_valid;
    assign w_op_fire  = (r_state == S_OPER)   && i_op_ready;
    assign w_res_fire = (r_state == S_RESULT) && i_res_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (i_req_valid) w_state_nxt = S_READ;
            S_READ:   w_state_nxt = S_LATCH;
            S_LATCH:  w_state_nxt = S_OPER;
            S_OPER:   if (i_op_ready) w_state_nxt = S_RESULT;
            S_RESULT: if (i_res_valid) w_state_nxt = r_req.wb_eff ? S_WRITE : S_IDLE;
            S_WRITE:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_req      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_res_lo   <= '0;
            r_mul_high <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_req_fire) begin
                r_req.src_a  <= i_req_src_a;
                r_req.src_b  <= i_req_src_b;
                r_req.dst    <= i_req_dst;
                r_req.mul    <= i_req_mul;
                r_req.wb_eff <= wb_effective(i_req_wb, i_req_mul);
            end
            // The file's registered read data is valid only during LATCH.
            if (r_state == S_LATCH) begin
                r_op_a <= i_rf_a_data;
                r_op_b <= i_rf_b_data;
            end
            if (w_res_fire) begin
                r_res_lo <= i_res_lo;
                if (r_req.mul) r_mul_high <= i_res_hi;
            end
        end
    end

    assign o_req_ready   = (r_state == S_IDLE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_op_valid    = (r_state == S_OPER);
    assign o_res_ready   = (r_state == S_RESULT);
    assign o_op_a        = r_op_a;
    assign o_op_b        = r_op_b;
    assign o_rf_read_en  = (r_state == S_READ);
    assign o_rf_write_en = (r_state == S_WRITE);
    assign o_rf_a_num    = r_req.src_a;
    assign o_rf_b_num    = r_req.src_b;
    assign o_rf_c_num    = r_req.dst;
    assign o_rf_c_data   = r_res_lo;
    // The file writes multiply-high on every write, so it must always see the shadow.
    assign o_rf_mul_high = r_mul_high;

    ap_rw_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_rf_read_en && o_rf_write_en));

endmodule

// File: tb/tb_gpr_port_sequencer.sv
// Directed vector table, reset-abort sequences and a random stream against a register-file model.
module tb_gpr_port_sequencer;
    import cpu_pkg::*;

    localparam int DW = CPU_DATA_W;
    localparam int IW = CPU_REG_IDX_W;

    logic          clk;
    logic          rst_n;
    logic          req_valid, req_ready, req_wb, req_mul;
    logic [IW-1:0] req_src_a, req_src_b, req_dst;
    logic          op_valid, op_ready, res_valid, res_ready;
    logic [DW-1:0] op_a, op_b, res_lo, res_hi;
    logic          rf_read_en, rf_write_en, busy;
    logic [IW-1:0] rf_a_num, rf_b_num, rf_c_num;
    logic [DW-1:0] rf_c_data, rf_mul_high, rf_a_data, rf_b_data;

    gpr_port_sequencer dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_src_a(req_src_a), .i_req_src_b(req_src_b), .i_req_dst(req_dst),
        .i_req_wb(req_wb), .i_req_mul(req_mul),
        .o_op_valid(op_valid), .i_op_ready(op_ready), .o_op_a(op_a), .o_op_b(op_b),
        .i_res_valid(res_valid), .o_res_ready(res_ready), .i_res_lo(res_lo), .i_res_hi(res_hi),
        .o_rf_read_en(rf_read_en), .o_rf_write_en(rf_write_en),
        .o_rf_a_num(rf_a_num), .o_rf_b_num(rf_b_num), .o_rf_c_num(rf_c_num),
        .o_rf_c_data(rf_c_data), .o_rf_mul_high(rf_mul_high),
        .i_rf_a_data(rf_a_data), .i_rf_b_data(rf_b_data), .o_busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: registered read, read has priority, backdoor preload port.
    logic [DW-1:0] rf_mem [8];
    logic [DW-1:0] rf_mh;
    logic          bd_en;
    logic [IW-1:0] bd_idx;
    logic [DW-1:0] bd_dat;
    int            viol;

    always @(posedge clk) begin
        if (bd_en) rf_mem[bd_idx] <= bd_dat;
        if (rf_read_en) begin
            rf_a_data <= rf_mem[rf_a_num];
            rf_b_data <= rf_mem[rf_b_num];
        end else if (rf_write_en) begin
            rf_mem[rf_c_num] <= rf_c_data;
            rf_mh            <= rf_mul_high;
        end
    end

    initial viol = 0;
    always @(negedge clk) if (rf_read_en && rf_write_en) viol++;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [IW-1:0] src_a, src_b, dst;
        logic          wb, mul;
        logic [DW-1:0] res_lo, res_hi, exp_a, exp_b;
        logic          exp_wr;
        logic [DW-1:0] exp_mh;
        int            op_stall, res_stall;
        logic          early;
    } vec_t;

    logic [DW-1:0] ref_regs [8];
    logic [DW-1:0] tb_shadow;

    task automatic backdoor(input logic [IW-1:0] idx, input logic [DW-1:0] dat);
        bd_en = 1'b1; bd_idx = idx; bd_dat = dat;
        @(negedge clk);
        bd_en = 1'b0;
        ref_regs[idx] = dat;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT in IDLE.
    task automatic do_op(input vec_t v);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_src_a = v.src_a; req_src_b = v.src_b;
        req_dst = v.dst; req_wb = v.wb; req_mul = v.mul;
        @(negedge clk);
        req_valid = 1'b0;
        req_src_a = ~v.src_a; req_src_b = ~v.src_b; req_dst = ~v.dst;
        req_wb = ~v.wb; req_mul = ~v.mul;
        if (v.early) begin op_ready = 1'b1; res_valid = 1'b1; end
        chk("read_en", rf_read_en, 1);
        chk("a_num", rf_a_num, v.src_a);
        chk("b_num", rf_b_num, v.src_b);
        chk("busy", busy, 1);
        @(negedge clk);
        chk("latch_read_en", rf_read_en, 0);
        chk("latch_op_valid", op_valid, 0);
        @(negedge clk);
        op_ready = 1'b0; res_valid = 1'b0;
        chk("op_valid", op_valid, 1);
        chk("op_a", op_a, v.exp_a);
        chk("op_b", op_b, v.exp_b);
        chk("oper_res_ready", res_ready, 0);
        for (int i = 0; i < v.op_stall; i++) begin
            @(negedge clk);
            chk("stall_op_valid", op_valid, 1);
            chk("stall_op_a", op_a, v.exp_a);
            chk("stall_op_b", op_b, v.exp_b);
            chk("stall_rf_idle", {rf_read_en, rf_write_en}, 0);
        end
        op_ready = 1'b1;
        @(negedge clk);
        op_ready = 1'b0;
        chk("result_op_valid", op_valid, 0);
        chk("result_res_ready", res_ready, 1);
        for (int i = 0; i < v.res_stall; i++) begin
            @(negedge clk);
            chk("stall_res_ready", res_ready, 1);
            chk("stall_res_rf_idle", {rf_read_en, rf_write_en}, 0);
        end
        res_valid = 1'b1; res_lo = v.res_lo; res_hi = v.res_hi;
        @(negedge clk);
        res_valid = 1'b0;
        if (v.exp_wr) begin
            chk("write_en", rf_write_en, 1);
            chk("write_read_en", rf_read_en, 0);
            chk("c_num", rf_c_num, v.dst);
            chk("c_data", rf_c_data, v.res_lo);
            chk("mul_high", rf_mul_high, v.exp_mh);
            chk("write_req_ready", req_ready, 0);
            @(negedge clk);
        end
        chk("post_write_en", rf_write_en, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_mul_high", rf_mul_high, v.exp_mh);
        if (v.exp_wr) ref_regs[v.dst] = v.res_lo;
    endtask

    vec_t tbl [6];
    vec_t v;
    int   wr_seen;
    logic [15:0] prod;

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_src_a = '0; req_src_b = '0; req_dst = '0;
        req_wb = 1'b0; req_mul = 1'b0; op_ready = 1'b0; res_valid = 1'b0;
        res_lo = '0; res_hi = '0; bd_en = 1'b0; bd_idx = '0; bd_dat = '0;
        tb_shadow = '0;

        // Fields: src_a src_b dst wb mul res_lo res_hi exp_a exp_b exp_wr exp_mh op_stall res_stall early
        tbl[0] = '{3'd2, 3'd5, 3'd3, 1'b1, 1'b0, 8'h1F, 8'h00, 8'h15, 8'h0A, 1'b1, 8'h00, 0, 0, 1'b0};
        tbl[1] = '{3'd2, 3'd5, 3'd1, 1'b0, 1'b1, 8'h40, 8'h12, 8'h15, 8'h0A, 1'b1, 8'h12, 0, 0, 1'b0};
        tbl[2] = '{3'd1, 3'd3, 3'd4, 1'b1, 1'b0, 8'h07, 8'hAA, 8'h40, 8'h1F, 1'b1, 8'h12, 0, 0, 1'b0};
        tbl[3] = '{3'd4, 3'd4, 3'd0, 1'b0, 1'b0, 8'h99, 8'h00, 8'h07, 8'h07, 1'b0, 8'h12, 4, 3, 1'b0};
        tbl[4] = '{3'd3, 3'd2, 3'd3, 1'b1, 1'b0, 8'h34, 8'h00, 8'h1F, 8'h15, 1'b1, 8'h12, 1, 0, 1'b1};
        tbl[5] = '{3'd3, 3'd1, 3'd5, 1'b0, 1'b0, 8'h00, 8'h00, 8'h34, 8'h40, 1'b0, 8'h12, 0, 2, 1'b0};

        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rf_en", {rf_read_en, rf_write_en}, 0);
        chk("rst_rf_nums", {rf_a_num, rf_b_num, rf_c_num}, 0);
        chk("rst_c_data", rf_c_data, 0);
        chk("rst_mul_high", rf_mul_high, 0);
        chk("rst_ops", {op_a, op_b}, 0);
        chk("rst_valid_ready", {op_valid, res_ready}, 0);
        rst_n = 1'b1;

        backdoor(3'd0, 8'h01); backdoor(3'd1, 8'h11); backdoor(3'd2, 8'h15);
        backdoor(3'd3, 8'h33); backdoor(3'd4, 8'h44); backdoor(3'd5, 8'h0A);
        backdoor(3'd6, 8'h66); backdoor(3'd7, 8'h77);

        for (int i = 0; i < 6; i++) do_op(tbl[i]);
        chk("r1_after_mul", rf_mem[1], 8'h40);
        chk("r3_after_raw", rf_mem[3], 8'h34);
        chk("r4_after_add", rf_mem[4], 8'h07);
        chk("rf_mh_kept", rf_mh, 8'h12);

        // Reset asserted while the sequencer waits in OPER.
        req_valid = 1'b1; req_src_a = 3'd2; req_src_b = 3'd5; req_dst = 3'd6;
        req_wb = 1'b1; req_mul = 1'b0;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_oper_op_valid", op_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_oper_op_valid_low", op_valid, 0);
        chk("abort_oper_busy", busy, 0);
        chk("abort_oper_ops", {op_a, op_b}, 0);
        chk("abort_oper_nums", {rf_a_num, rf_b_num, rf_c_num}, 0);
        chk("abort_oper_mul_high", rf_mul_high, 0);
        chk("abort_oper_req_ready", req_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rf_write_en || busy) wr_seen++;
        end
        chk("abort_oper_quiet", wr_seen, 0);
        chk("abort_oper_r6", rf_mem[6], 8'h66);
        tb_shadow = '0;
        do_op('{3'd2, 3'd5, 3'd6, 1'b0, 1'b0, 8'h00, 8'h00, 8'h15, 8'h0A, 1'b0, 8'h00, 0, 0, 1'b0});

        // Reset asserted during the WRITE cycle of a multiply.
        req_valid = 1'b1; req_src_a = 3'd2; req_src_b = 3'd5; req_dst = 3'd7;
        req_wb = 1'b0; req_mul = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); op_ready = 1'b1;
        @(negedge clk); op_ready = 1'b0; res_valid = 1'b1; res_lo = 8'h55; res_hi = 8'h66;
        @(negedge clk); res_valid = 1'b0;
        chk("abort_write_en", rf_write_en, 1);
        chk("abort_write_mh", rf_mul_high, 8'h66);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_write_en_low", rf_write_en, 0);
        chk("abort_write_data", {rf_c_num, rf_c_data, rf_mul_high}, 0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("abort_write_r7", rf_mem[7], 8'h77);
        do_op('{3'd7, 3'd2, 3'd0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h77, 8'h15, 1'b0, 8'h00, 0, 0, 1'b0});

        // Random stream checked against the reference register/ALU model.
        for (int n = 0; n < 200; n++) begin
            v.src_a = IW'($urandom_range(0, 7));
            v.src_b = IW'($urandom_range(0, 7));
            v.dst   = IW'($urandom_range(0, 7));
            v.mul   = ($urandom_range(0, 3) == 0);
            v.wb    = ($urandom_range(0, 2) != 0);
            v.exp_a = ref_regs[v.src_a];
            v.exp_b = ref_regs[v.src_b];
            prod = {8'h00, v.exp_a} * {8'h00, v.exp_b};
            if (v.mul) begin
                v.res_lo = prod[7:0]; v.res_hi = prod[15:8]; tb_shadow = prod[15:8];
            end else begin
                v.res_lo = v.exp_a + v.exp_b; v.res_hi = DW'($urandom);
            end
            v.exp_wr    = v.wb | v.mul;
            v.exp_mh    = tb_shadow;
            v.op_stall  = $urandom_range(0, 3);
            v.res_stall = $urandom_range(0, 3);
            v.early     = $urandom_range(0, 1) == 1;
            do_op(v);
        end
        for (int i = 0; i < 8; i++) chk("final_reg", rf_mem[i], ref_regs[i]);
        chk("final_mh", rf_mh, tb_shadow);
        chk("rw_exclusive", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpr_port_sequencer.md
Name: gpr_port_sequencer

Overview:
- Client-side controller for the 8-entry general-purpose register file; sits between instruction decode and the ALU.
- Drives the register file's read/write port one operation at a time: read two source registers, wait out the file's one-cycle registered-read latency, hand operands to the ALU, then write back the result.
- Keeps a shadow copy of the multiply-high register so that ordinary writebacks never corrupt it.

Parameters:
- DATA_W, 8, register/operand width
- REG_IDX_W, 3, register index width (8 registers)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  decode presents an operation
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_src_a  in  REG_IDX_W  source register A index
- req_src_b  in  REG_IDX_W  source register B index
- req_dst  in  REG_IDX_W  destination register index
- req_wb  in  1  write result back to req_dst
- req_mul  in  1  operation is a multiply: res_hi goes to multiply-high
- op_valid  out  1  operands valid to ALU
- op_ready  in  1  ALU accepts operands
- op_a  out  DATA_W  operand A
- op_b  out  DATA_W  operand B
- res_valid  in  1  ALU result valid
- res_ready  out  1  sequencer accepts result
- res_lo  in  DATA_W  result low byte
- res_hi  in  DATA_W  result high byte (used only for multiply)
- rf_read_en  out  1  register file read enable
- rf_write_en  out  1  register file write enable
- rf_a_num  out  REG_IDX_W  register file read index A
- rf_b_num  out  REG_IDX_W  register file read index B
- rf_c_num  out  REG_IDX_W  register file write index
- rf_c_data  out  DATA_W  register file write data
- rf_mul_high  out  DATA_W  register file multiply-high write data
- rf_a_data  in  DATA_W  register file read data A (registered inside the file)
- rf_b_data  in  DATA_W  register file read data B
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; all rf_* outputs 0; op_a = op_b = 0; op_valid = res_ready = 0; mul_high shadow = 0; captured request fields = 0. Reset mid-operation aborts immediately; no partial write is issued after release.
- States: IDLE, READ, LATCH, OPER, RESULT, WRITE.
- IDLE: req_ready = 1. On req_valid at a clock edge, capture src_a, src_b, dst and mul. Set the effective writeback flag wb_eff = req_wb | req_mul. Go to READ.
- READ, one cycle: rf_read_en = 1, rf_a_num = src_a, rf_b_num = src_b. The file updates its read outputs at the end of this cycle.
- LATCH, one cycle: rf_read_en = 0. op_a/op_b load rf_a_data/rf_b_data at the ending edge. Go to OPER.
- OPER: op_valid = 1; op_a/op_b held stable. On op_ready, go to RESULT. op_valid falls in the following cycle.
- RESULT: res_ready = 1. On res_valid, capture res_lo; if mul, also capture res_hi into the shadow. Then go to WRITE if wb_eff, otherwise go to IDLE.
- WRITE, one cycle: rf_write_en = 1, rf_c_num = dst, rf_c_data = captured res_lo, rf_mul_high = shadow. Then go to IDLE.
- rf_mul_high always equals the shadow value. Because the file writes multiply-high on every write, a non-multiply write re-writes the unchanged shadow value.
- rf_read_en and rf_write_en are never high in the same cycle. This is a checked invariant, since the file gives read priority.
- Latency: req accepted at edge N gives op_valid high in cycle N+3. A res_valid handshake at edge M gives rf_write_en high in cycle M+1.
- Back-to-back: req_ready is high only in IDLE. The minimum issue interval is 5 cycles without writeback, 6 with.
- Read-after-write to the same register needs no forwarding: a write completes before the next READ.
- src_a == src_b is legal; both operands get the same value.
- dst equal to a source is legal; the old value is used as the operand.
- op_ready/res_valid held high early are ignored outside OPER/RESULT.

Decomposition:
- Shared package cpu_pkg: DATA_W and REG_IDX_W constants, plus the sequencer state enum (IDLE..WRITE) for reuse by the bench and the debug trace.
- Single module, no sub-module. The shadow register and FSM are small enough to stay inline.

Test Plan:
- Reset, then preload R2=0x15, R5=0x0A via a backdoor. Request src_a=2, src_b=5, dst=3, wb=1; ALU returns res_lo=0x1F. Expect op_a=0x15, op_b=0x0A in cycle N+3, then one rf_write_en pulse with c_num=3, c_data=0x1F, mul_high=0x00.
- Multiply request with dst=1; ALU returns res_lo=0x40, res_hi=0x12. Expect the write to carry mul_high=0x12. Then a plain add to R4 = 0x07 must still drive rf_mul_high=0x12.
- Request with wb=0, mul=0: expect no rf_write_en pulse, return to IDLE, and req_ready high in the cycle after the res handshake.
- Hold op_ready low 4 cycles, then res_valid low 3 cycles: expect op_a/op_b stable and op_valid high throughout, with no rf activity.
- Assert rst_n low during OPER and again during WRITE: outputs go to 0 asynchronously, no write pulse follows, and the next request reads correctly.
- Random stream of 200 operations with random stalls: rf_read_en & rf_write_en never both high, and the register-file model matches the reference ALU model.
